// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns host frames (16-bit header + 16-bit data words) into
// register-bus read/write strobes, with burst address auto-increment.
module spi_reg_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_sck,
    input  logic                  spi_ss_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  bus_en,
    output logic                  bus_rd,
    output logic                  bus_wr,
    output logic [1:0]            bus_be,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_dout,
    input  logic [DATA_WIDTH-1:0] bus_din,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE, HEADER, WR_DATA, WR_S1, WR_S2, RD_FETCH, RD_DATA
    } state_t;

    state_t                state, state_next;
    logic [1:0]            sck_sync, ss_sync, mosi_sync;
    logic                  sck_prev;
    logic                  sck_rise, sck_fall, ss_n_s, mosi_s;
    logic [4:0]            bit_cnt;
    logic                  fetch_second;
    logic [DATA_WIDTH-1:0] shift_in, shift_out, word_next;

    // Header address field is bits[14:0]; bit 15 is the write flag and never part of the address.
    function automatic logic [ADDR_WIDTH-1:0] hdr_addr(input logic [DATA_WIDTH-1:0] hdr);
        logic [ADDR_WIDTH-1:0] a;
        a = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (i < DATA_WIDTH - 1) a[i] = hdr[i];
        end
        return a;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync  <= 2'b00;
            ss_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_sck};
            ss_sync   <= {ss_sync[0], spi_ss_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_prev  <= sck_sync[1];
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_prev;
    assign sck_fall  = ~sck_sync[1] & sck_prev;
    assign ss_n_s    = ss_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign word_next = {shift_in[DATA_WIDTH-2:0], mosi_s};

    always_comb begin
        state_next  = state;
        bus_en      = 1'b0;
        bus_rd      = 1'b0;
        bus_wr      = 1'b0;
        busy        = (state != IDLE) && (state != HEADER);
        spi_miso_oe = ((state == RD_FETCH) || (state == RD_DATA)) && !ss_n_s;
        case (state)
            IDLE:    if (!ss_n_s) state_next = HEADER;
            HEADER: begin
                if (ss_n_s)                                state_next = IDLE;
                else if (sck_rise && bit_cnt == 5'd15)     state_next = word_next[DATA_WIDTH-1] ? WR_DATA : RD_FETCH;
            end
            WR_DATA: begin
                if (ss_n_s)                                state_next = IDLE;
                else if (sck_rise && bit_cnt == 5'd15)     state_next = WR_S1;
            end
            WR_S1: begin
                bus_en     = 1'b1;
                bus_wr     = 1'b1;
                state_next = WR_S2;
            end
            WR_S2: begin
                bus_en     = 1'b1;
                state_next = ss_n_s ? IDLE : WR_DATA;
            end
            RD_FETCH: begin
                bus_en = 1'b1;
                bus_rd = 1'b1;
                if (fetch_second) state_next = ss_n_s ? IDLE : RD_DATA;
            end
            RD_DATA: begin
                if (ss_n_s)                                state_next = IDLE;
                else if (sck_fall && bit_cnt == 5'd16)     state_next = RD_FETCH;
            end
            default: state_next = IDLE;
        endcase
        bus_be = bus_en ? 2'b11 : 2'b00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            fetch_second <= 1'b0;
            bus_addr     <= '0;
            bus_dout     <= '0;
            spi_miso     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    bit_cnt      <= '0;
                    fetch_second <= 1'b0;
                    spi_miso     <= 1'b0;
                end
                HEADER: if (sck_rise) begin
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd15) begin
                        bus_addr <= hdr_addr(word_next);
                        bit_cnt  <= '0;
                    end
                end
                WR_DATA: if (sck_rise) begin
                    bit_cnt <= bit_cnt + 5'd1;
                    if (state_next == WR_S1) bus_dout <= word_next;
                end
                WR_S2: begin
                    bus_addr <= bus_addr + ADDR_WIDTH'(1);
                    bit_cnt  <= '0;
                end
                RD_FETCH: begin
                    fetch_second <= ~fetch_second;
                    if (fetch_second) begin
                        spi_miso <= bus_din[DATA_WIDTH-1];
                        bit_cnt  <= '0;
                    end
                end
                RD_DATA: begin
                    if (sck_rise) bit_cnt <= bit_cnt + 5'd1;
                    // A fall before the first rise is the trailing edge of the previous frame.
                    if (sck_fall && bit_cnt == 5'd16)    bus_addr <= bus_addr + ADDR_WIDTH'(1);
                    else if (sck_fall && bit_cnt != '0)  spi_miso <= shift_out[DATA_WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == HEADER || state == WR_DATA) && sck_rise)
            shift_in <= word_next;
        if (state == RD_FETCH && fetch_second)
            shift_out <= {bus_din[DATA_WIDTH-2:0], 1'b0};
        else if (state == RD_DATA && sck_fall && bit_cnt != '0 && bit_cnt != 5'd16)
            shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};
    end

endmodule
